// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester handshake and RAM port bundle for mem_port_arbiter.
//               master = arbiter side, slave = clients plus RAM macro side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_READY;
  logic [NREQ-1:0]    REQ_WE;
  logic [NREQ-1:0]    REQ_LOCK;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_WDATA;
  logic [NREQ-1:0]    RSP_VALID;
  logic [DW-1:0]      RSP_DATA;
  logic [AW-1:0]      MEM_ADDR;
  logic               MEM_WE;
  logic [DW-1:0]      MEM_D;
  logic [DW-1:0]      MEM_Q;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_LOCK, REQ_ADDR, REQ_WDATA, MEM_Q,
    output REQ_READY, RSP_VALID, RSP_DATA, MEM_ADDR, MEM_WE, MEM_D
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_LOCK, REQ_ADDR, REQ_WDATA, MEM_Q,
    input  REQ_READY, RSP_VALID, RSP_DATA, MEM_ADDR, MEM_WE, MEM_D
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one single-port synchronous RAM
//               among NREQ requesters, with bounded per-requester locking and
//               read-data return to the originating requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic               CLK,
  input  logic               RST_X,
  mem_port_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nxt;
  logic [CW-1:0]   r_lock_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_rsp_pend;
  logic [IW-1:0]   r_rsp_id;
  logic [IW:0]     w_pick;
  logic            w_grant;
  logic            w_gnt;
  logic [IW-1:0]   w_win;

  // Next index after v, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + IW'(1);
  endfunction

  // {found, index} of the first valid requester scanning start, start+1, ...
  // Scanning from the far end and overwriting leaves the nearest hit.
  function automatic logic [IW:0] rr_pick(input logic [IW-1:0] start,
                                          input logic [NREQ-1:0] valid);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (valid[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  // Arbitration, pointer update and lock FSM next-state.
  always_comb begin
    w_pick      = rr_pick(r_ptr, bus.REQ_VALID);
    w_grant     = 1'b0;
    w_win       = '0;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[IW]) begin
          w_grant   = 1'b1;
          w_win     = w_pick[IW-1:0];
          w_ptr_nxt = inc_mod(w_pick[IW-1:0]);
          // A lock limit of one would release immediately, so never lock.
          if (bus.REQ_LOCK[w_pick[IW-1:0]] && (MAX_LOCK > 1)) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_pick[IW-1:0];
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        // Only the owner may transfer; everyone else waits even if it idles.
        w_win = r_owner;
        if (bus.REQ_VALID[r_owner]) begin
          w_grant = 1'b1;
          if (bus.REQ_LOCK[r_owner] && (r_lock_cnt != CW'(MAX_LOCK - 1))) begin
            w_cnt_nxt = r_lock_cnt + CW'(1);
          end else begin
            // Voluntary release or lock budget exhausted on this transfer.
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = inc_mod(r_owner);
            w_cnt_nxt   = '0;
          end
        end else if (!bus.REQ_LOCK[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = inc_mod(r_owner);
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant strobes, RAM drive and read-response routing; all quiet in reset.
  always_comb begin
    w_gnt         = w_grant & ~RST_X;
    bus.REQ_READY = '0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_ADDR  = '0;
    bus.MEM_D     = '0;
    bus.RSP_VALID = '0;
    bus.RSP_DATA  = '0;
    if (w_gnt) begin
      bus.REQ_READY[w_win] = 1'b1;
      bus.MEM_WE           = bus.REQ_WE[w_win];
      bus.MEM_ADDR         = bus.REQ_ADDR[w_win*AW +: AW];
      bus.MEM_D            = bus.REQ_WDATA[w_win*DW +: DW];
    end
    if (r_rsp_pend && !RST_X) begin
      bus.RSP_VALID[r_rsp_id] = 1'b1;
      bus.RSP_DATA            = bus.MEM_Q;
    end
  end

  // State registers; a granted read arms a one-cycle response to its origin.
  always_ff @(posedge CLK) begin
    if (RST_X) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_rsp_pend <= 1'b0;
      r_rsp_id   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_cnt_nxt;
      r_rsp_pend <= w_grant & ~bus.REQ_WE[w_win];
      r_rsp_id   <= w_win;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               single-port RAM and a read-response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  localparam logic [31:0] ADDR_DEF  = 32'h2322_2120;
  localparam logic [31:0] WDATA_DEF = 32'hB3B2_B1B0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  logic [7:0] ram_q;
  rsp_t sb[$];
  vec_t tbl[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_LOCK(8)) dut (
    .CLK   (clk),
    .RST_X (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read address, write lands before later reads.
  always @(posedge clk) begin
    if (bus.MEM_WE) ram[bus.MEM_ADDR] <= bus.MEM_D;
    ram_q <= ram[bus.MEM_ADDR];
  end
  assign bus.MEM_Q = ram_q;

  function automatic vec_t mk(input logic rst_i, input logic [3:0] valid,
                              input logic [3:0] we, input logic [3:0] lock,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] exp_ready);
    vec_t v;
    v.rst = rst_i; v.valid = valid; v.we = we; v.lock = lock;
    v.addr = addr; v.wdata = wdata; v.exp_ready = exp_ready;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] exp_rv;
    logic [7:0] exp_rd;
    logic       exp_we;
    logic [7:0] exp_a;
    logic [7:0] exp_d;
    logic [7:0] a;
    rsp_t       e;
    rsp_t       n;
    @(negedge clk);
    rst           = v.rst;
    bus.REQ_VALID = v.valid;
    bus.REQ_WE    = v.we;
    bus.REQ_LOCK  = v.lock;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_WDATA = v.wdata;
    #2;
    chk("ready", {28'd0, bus.REQ_READY}, {28'd0, v.exp_ready});
    exp_we = 1'b0; exp_a = 8'h00; exp_d = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (v.exp_ready[i]) begin
        exp_we = v.we[i];
        exp_a  = v.addr[i*8 +: 8];
        exp_d  = v.wdata[i*8 +: 8];
      end
    end
    chk("mem_we_addr_d", {15'd0, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_D},
        {15'd0, exp_we, exp_a, exp_d});
    exp_rv = 4'b0000; exp_rd = 8'h00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (!v.rst) begin
        exp_rv = 4'b0001 << e.id;
        exp_rd = e.data;
      end
    end
    chk("rsp_valid_data", {20'd0, bus.RSP_VALID, bus.RSP_DATA}, {20'd0, exp_rv, exp_rd});
    if (!v.rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (v.exp_ready[i]) begin
          a = v.addr[i*8 +: 8];
          if (v.we[i]) begin
            shadow[a] = v.wdata[i*8 +: 8];
          end else begin
            n.due = cyc + 1; n.id = i; n.data = shadow[a];
            sb.push_back(n);
          end
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    n_vec = 0; n_err = 0; cyc = 0;
    ram_q = 8'h00;
    for (int a = 0; a < 256; a++) begin
      ram[a]    = 8'(a) ^ 8'h3C;
      shadow[a] = 8'(a) ^ 8'h3C;
    end
    rst = 1'b1;
    bus.REQ_VALID = '0; bus.REQ_WE = '0; bus.REQ_LOCK = '0;
    bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;

    // Reset with requests pending, then an idle stretch.
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0000));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b0001, 4'b0001, ADDR_DEF, WDATA_DEF, 4'b0000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0000));
    // Req0 writes 0x10=0xA5, req2 reads it back next cycle.
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0001, 4'b0000, 32'h2322_2110, 32'hB3B2_B1A5, 4'b0001));
    tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h2310_2120, WDATA_DEF, 4'b0100));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0000));
    // Bring ptr back to 0 via req3, then all four contend for 8 cycles.
    tbl.push_back(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b1000));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF,
                       4'b0001 << (i % 4)));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0000));

    foreach (tbl[k]) apply(tbl[k]);

    // Req1 locks for 12 cycles against req3: 8 grants, forced release,
    // req3 once, then req1 relocks. Req1 alternates writes/reads on 0x40.
    addr = 32'h4022_4020;
    for (int k = 0; k < 12; k++) begin
      we    = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      wdata = {8'hB3, 8'hB2, 8'(8'h60 + k), 8'hB0};
      apply(mk(1'b0, 4'b1010, we, 4'b0010, addr, wdata,
               (k == 8) ? 4'b1000 : 4'b0010));
    end
    // Owner drops VALID and LOCK: one empty cycle, then req3.
    apply(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, addr, WDATA_DEF, 4'b0000));
    apply(mk(1'b0, 4'b1000, 4'b0000, 4'b0000, addr, WDATA_DEF, 4'b1000));

    // Idle owner holding LOCK blocks others; voluntary release still transfers.
    apply(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, ADDR_DEF, WDATA_DEF, 4'b0001));
    apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0001, ADDR_DEF, WDATA_DEF, 4'b0000));
    apply(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0001));
    apply(mk(1'b0, 4'b0101, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0100));

    // Reset right after a locked read grant: response dropped, lock cleared.
    apply(mk(1'b0, 4'b0001, 4'b0000, 4'b0001, ADDR_DEF, WDATA_DEF, 4'b0001));
    apply(mk(1'b1, 4'b0101, 4'b0000, 4'b0001, ADDR_DEF, WDATA_DEF, 4'b0000));
    apply(mk(1'b0, 4'b0100, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0100));
    apply(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, ADDR_DEF, WDATA_DEF, 4'b0000));

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
